// File: rtl/dma_pkg.sv
// Shared constants for the DMA control register block: register map, bit positions,
// AXI response codes and the write/read channel FSM encodings.
package dma_pkg;

   // Register byte offsets
   localparam int unsigned REG_CTRL   = 32'h00;
   localparam int unsigned REG_STATUS = 32'h04;
   localparam int unsigned REG_SRC    = 32'h08;
   localparam int unsigned REG_DST    = 32'h0C;
   localparam int unsigned REG_LEN    = 32'h10;
   localparam int unsigned REG_DATA   = 32'h14;

   // CTRL bits
   localparam int unsigned CTRL_START_BIT  = 0;
   localparam int unsigned CTRL_IRQ_EN_BIT = 1;

   // STATUS bits
   localparam int unsigned STAT_BUSY_BIT = 0;
   localparam int unsigned STAT_DONE_BIT = 1;
   localparam int unsigned STAT_ERR_BIT  = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_RESP} rd_state_e;

   // Byte-lane merge of a write into an existing 32-bit register value
   function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dma_ctrl_regs.sv
// AXI4-Lite register file in front of the copy engine: holds the command operands,
// issues the one-cycle start strobe, tracks busy/done/error and drives the interrupt.
module dma_ctrl_regs
   import dma_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int C_S_AXI_DATA_WIDTH = 32
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            start,
   output logic [31:0]                     address_src,
   output logic [31:0]                     address_dst,
   output logic [31:0]                     length,
   output logic [31:0]                     data,
   input  logic                            eng_done,
   input  logic                            eng_error,
   output logic                            irq
);

   localparam int AW = C_S_AXI_ADDR_WIDTH;

   wr_state_e         wr_q, wr_d;
   rd_state_e         rd_q, rd_d;
   logic [AW-1:0]     awaddr_q, awaddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [31:0]       src_q, src_d, dst_q, dst_d, len_q, len_d, data_q, data_d;
   logic              irq_en_q, irq_en_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic              start_q, start_d, irq_q, irq_d;
   logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              aw_hs, w_hs, ar_hs, commit;
   logic [AW-1:0]     eff_awaddr, waddr_word, raddr_word;
   logic [31:0]       eff_wdata;
   logic [3:0]        eff_wstrb;
   logic              start_req, w1c_done, w1c_err, busy_free, start_go, start_zero;
   logic              unused_bits;

   assign S_AXI_AWREADY = (wr_q == W_IDLE) || (wr_q == W_HAVE_W);
   assign S_AXI_WREADY  = (wr_q == W_IDLE) || (wr_q == W_HAVE_AW);
   assign S_AXI_BVALID  = (wr_q == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = (rd_q == R_IDLE);
   assign S_AXI_RVALID  = (rd_q == R_RESP);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign start         = start_q;
   assign irq           = irq_q;
   assign address_src   = src_q;
   assign address_dst   = dst_q;
   assign length        = len_q;
   assign data          = data_q;

   assign aw_hs      = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs       = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;
   assign eff_awaddr = (wr_q == W_HAVE_AW) ? awaddr_q : S_AXI_AWADDR;
   assign eff_wdata  = (wr_q == W_HAVE_W) ? wdata_q : S_AXI_WDATA;
   assign eff_wstrb  = (wr_q == W_HAVE_W) ? wstrb_q : S_AXI_WSTRB;
   assign waddr_word = {eff_awaddr[AW-1:2], 2'b00};
   assign raddr_word = {S_AXI_ARADDR[AW-1:2], 2'b00};
   assign irq_d      = irq_en_q & (done_q | err_q);

   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, eff_awaddr[1:0], S_AXI_ARADDR[1:0]};

   // Write channel: collect AW and W independently, commit once both are held
   always_comb begin
      wr_d     = wr_q;
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      commit   = 1'b0;
      if (aw_hs) awaddr_d = S_AXI_AWADDR;
      if (w_hs) begin
         wdata_d = S_AXI_WDATA;
         wstrb_d = S_AXI_WSTRB;
      end
      unique case (wr_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_d   = W_RESP;
               commit = 1'b1;
            end else if (aw_hs) begin
               wr_d = W_HAVE_AW;
            end else if (w_hs) begin
               wr_d = W_HAVE_W;
            end
         end
         W_HAVE_AW: if (w_hs) begin
            wr_d   = W_RESP;
            commit = 1'b1;
         end
         W_HAVE_W: if (aw_hs) begin
            wr_d   = W_RESP;
            commit = 1'b1;
         end
         W_RESP: if (S_AXI_BREADY) wr_d = W_IDLE;
         default: wr_d = W_IDLE;
      endcase
   end

   // Register updates and engine status; engine set events beat W1C clears, START beats done
   always_comb begin
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      data_d     = data_q;
      irq_en_d   = irq_en_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      bresp_d    = bresp_q;
      start_d    = 1'b0;
      start_req  = 1'b0;
      w1c_done   = 1'b0;
      w1c_err    = 1'b0;
      if (commit) begin
         bresp_d = RESP_OKAY;
         case (waddr_word)
            AW'(REG_CTRL): if (eff_wstrb[0]) begin
               irq_en_d  = eff_wdata[CTRL_IRQ_EN_BIT];
               start_req = eff_wdata[CTRL_START_BIT];
            end
            AW'(REG_STATUS): if (eff_wstrb[0]) begin
               w1c_done = eff_wdata[STAT_DONE_BIT];
               w1c_err  = eff_wdata[STAT_ERR_BIT];
            end
            AW'(REG_SRC): if (busy_q) bresp_d = RESP_SLVERR;
                          else src_d = merge_strb(src_q, eff_wdata, eff_wstrb) & ~32'h3;
            AW'(REG_DST): if (busy_q) bresp_d = RESP_SLVERR;
                          else dst_d = merge_strb(dst_q, eff_wdata, eff_wstrb) & ~32'h3;
            AW'(REG_LEN): if (busy_q) bresp_d = RESP_SLVERR;
                          else len_d = merge_strb(len_q, eff_wdata, eff_wstrb) & ~32'h3;
            AW'(REG_DATA): if (busy_q) bresp_d = RESP_SLVERR;
                           else data_d = merge_strb(data_q, eff_wdata, eff_wstrb);
            default: bresp_d = RESP_SLVERR;
         endcase
      end
      // A completion arriving this cycle frees the engine for a coincident START
      busy_free  = !busy_q || eng_done;
      start_go   = start_req && busy_free && (len_q != 32'd0);
      start_zero = start_req && busy_free && (len_q == 32'd0);
      if (eng_done) busy_d = 1'b0;
      if (w1c_done) done_d = 1'b0;
      if (eng_done) done_d = 1'b1;
      if (w1c_err) err_d = 1'b0;
      if (eng_error || start_zero) err_d = 1'b1;
      if (start_go) begin
         start_d = 1'b1;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end
   end

   // Read channel: capture read data at AR acceptance, hold until RREADY
   always_comb begin
      rd_d    = rd_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      unique case (rd_q)
         R_IDLE: if (ar_hs) begin
            rd_d    = R_RESP;
            rresp_d = RESP_OKAY;
            case (raddr_word)
               AW'(REG_CTRL):   rdata_d = {30'd0, irq_en_q, 1'b0};
               AW'(REG_STATUS): rdata_d = {29'd0, err_q, done_q, busy_q};
               AW'(REG_SRC):    rdata_d = src_q;
               AW'(REG_DST):    rdata_d = dst_q;
               AW'(REG_LEN):    rdata_d = len_q;
               AW'(REG_DATA):   rdata_d = data_q;
               default: begin
                  rdata_d = 32'd0;
                  rresp_d = RESP_SLVERR;
               end
            endcase
         end
         R_RESP: if (S_AXI_RREADY) rd_d = R_IDLE;
         default: rd_d = R_IDLE;
      endcase
   end

   // State registers; reset abandons any in-flight handshake and kills the start strobe
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         wr_q     <= W_IDLE;
         rd_q     <= R_IDLE;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         data_q   <= '0;
         irq_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         start_q  <= 1'b0;
         irq_q    <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         awaddr_q <= awaddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         data_q   <= data_d;
         irq_en_q <= irq_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         start_q  <= start_d;
         irq_q    <= irq_d;
         bresp_q  <= bresp_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_dma_ctrl_regs.sv
// Self-checking bench for dma_ctrl_regs: table-driven register write/readback plus
// hand-written sequences for the start/done/error and reset corner cases.
module tb_dma_ctrl_regs;

   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] ERR = 2'b10;

   logic        S_AXI_ACLK = 1'b0;
   logic        S_AXI_ARESET;
   logic [4:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [4:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        start;
   logic [31:0] address_src, address_dst, length, data;
   logic        eng_done, eng_error, irq;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int s0;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      string       name;
   } rd_exp_t;
   rd_exp_t sb_q[$];

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] wd;
      logic [3:0]  strb;
      logic [1:0]  bresp;
      logic [31:0] rd;
      logic [1:0]  rresp;
      string       name;
   } vec_t;
   vec_t vecs[7];

   dma_ctrl_regs #(.C_S_AXI_ADDR_WIDTH(5), .C_S_AXI_DATA_WIDTH(32)) dut (
      .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .start(start), .address_src(address_src), .address_dst(address_dst),
      .length(length), .data(data), .eng_done(eng_done), .eng_error(eng_error), .irq(irq)
   );

   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   // Count start strobes, sampled mid-cycle
   always @(negedge S_AXI_ACLK) if (start) start_cnt++;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   // Full write with AW and W together; optional eng_done in the commit cycle
   task automatic axi_write(input logic [4:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                            input logic [1:0] exp, input logic pulse_done, input string name);
      int n;
      S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = wd; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
      eng_done = pulse_done;
      @(posedge S_AXI_ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; eng_done = 1'b0;
      n = 0;
      while (!S_AXI_BVALID && n < 16) begin
         @(posedge S_AXI_ACLK); #1; n++;
      end
      check({name, "_bvalid"}, 32'(S_AXI_BVALID), 32'd1);
      check({name, "_bresp"}, 32'(S_AXI_BRESP), 32'(exp));
      @(posedge S_AXI_ACLK); #1;
   endtask

   // Read: expectation queued at AR issue, compared when RVALID appears
   task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input logic pulse_done, input string name);
      int n;
      rd_exp_t e;
      sb_q.push_back('{exp_d, exp_r, name});
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; eng_done = pulse_done;
      @(posedge S_AXI_ACLK); #1;
      S_AXI_ARVALID = 1'b0; eng_done = 1'b0;
      n = 0;
      while (!S_AXI_RVALID && n < 16) begin
         @(posedge S_AXI_ACLK); #1; n++;
      end
      e = sb_q.pop_front();
      if (!S_AXI_RVALID) begin
         check({e.name, "_rvalid_timeout"}, 32'(S_AXI_RVALID), 32'd1);
      end else begin
         check({e.name, "_rdata"}, S_AXI_RDATA, e.data);
         check({e.name, "_rresp"}, 32'(S_AXI_RRESP), 32'(e.resp));
      end
      @(posedge S_AXI_ACLK); #1;
   endtask

   task automatic pulse(input logic is_err);
      if (is_err) eng_error = 1'b1; else eng_done = 1'b1;
      @(posedge S_AXI_ACLK); #1;
      eng_error = 1'b0; eng_done = 1'b0;
   endtask

   initial begin
      vecs[0] = '{5'h08, 32'h1000_0003, 4'hF, OK, 32'h1000_0000, OK, "src"};
      vecs[1] = '{5'h0C, 32'h2000_0000, 4'hF, OK, 32'h2000_0000, OK, "dst"};
      vecs[2] = '{5'h10, 32'h0000_0040, 4'hF, OK, 32'h0000_0040, OK, "len"};
      vecs[3] = '{5'h14, 32'hDEAD_BEEF, 4'hF, OK, 32'hDEAD_BEEF, OK, "data"};
      vecs[4] = '{5'h14, 32'h1122_3344, 4'h5, OK, 32'hDE22_BE44, OK, "data_strb"};
      vecs[5] = '{5'h18, 32'hFFFF_FFFF, 4'hF, ERR, 32'h0, ERR, "unmapped18"};
      vecs[6] = '{5'h1C, 32'hFFFF_FFFF, 4'hF, ERR, 32'h0, ERR, "unmapped1c"};

      S_AXI_ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
      eng_done = 1'b0; eng_error = 1'b0;
      repeat (3) @(posedge S_AXI_ACLK);
      #1 S_AXI_ARESET = 1'b0;

      // Reset state
      check("reset_ready", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
      check("reset_valid", {29'd0, S_AXI_BVALID, S_AXI_RVALID, start}, 32'h0);
      check("reset_irq", 32'(irq), 32'd0);
      for (int i = 0; i < 6; i++) axi_read(5'(i * 4), 32'h0, OK, 1'b0, $sformatf("rst_reg%0d", i));

      // Table-driven writes and readback
      for (int i = 0; i < 7; i++) begin
         axi_write(vecs[i].addr, vecs[i].wd, vecs[i].strb, vecs[i].bresp, 1'b0, vecs[i].name);
         axi_read(vecs[i].addr, vecs[i].rd, vecs[i].rresp, 1'b0, vecs[i].name);
      end
      check("out_src", address_src, 32'h1000_0000);
      check("out_data", data, 32'hDE22_BE44);

      // AW three cycles ahead of W
      S_AXI_AWADDR = 5'h14; S_AXI_AWVALID = 1'b1;
      @(posedge S_AXI_ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      check("aw_held_ready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h1);
      repeat (2) begin @(posedge S_AXI_ACLK); #1; end
      check("aw_held_nob", 32'(S_AXI_BVALID), 32'd0);
      S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      @(posedge S_AXI_ACLK); #1;
      S_AXI_WVALID = 1'b0;
      check("aw_first_bvalid", 32'(S_AXI_BVALID), 32'd1);
      check("aw_first_data", data, 32'hCAFE_F00D);
      @(posedge S_AXI_ACLK); #1;
      check("aw_first_after", {29'd0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);

      // START with IRQ_EN
      s0 = start_cnt;
      S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h3; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      @(posedge S_AXI_ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check("start_high", {30'd0, start, S_AXI_BVALID}, 32'h3);
      @(posedge S_AXI_ACLK); #1;
      check("start_low", 32'(start), 32'd0);
      check("start_once", start_cnt - s0, 32'd1);
      axi_read(5'h04, 32'h1, OK, 1'b0, "status_busy");
      axi_read(5'h00, 32'h2, OK, 1'b0, "ctrl_read");

      // Operand write and START while busy
      axi_write(5'h08, 32'hAAAA_0000, 4'hF, ERR, 1'b0, "src_busy");
      axi_read(5'h08, 32'h1000_0000, OK, 1'b0, "src_busy_rb");
      s0 = start_cnt;
      axi_write(5'h00, 32'h3, 4'hF, OK, 1'b0, "start_busy");
      repeat (2) @(posedge S_AXI_ACLK); #1;
      check("start_busy_nostrobe", start_cnt - s0, 32'd0);

      // Completion and interrupt
      pulse(1'b0);
      check("irq_lag", 32'(irq), 32'd0);
      @(posedge S_AXI_ACLK); #1;
      check("irq_set", 32'(irq), 32'd1);
      axi_read(5'h04, 32'h2, OK, 1'b0, "status_done");
      axi_write(5'h04, 32'h2, 4'hF, OK, 1'b0, "w1c_done");
      check("irq_clear", 32'(irq), 32'd0);

      // START with zero length
      axi_write(5'h10, 32'h0, 4'hF, OK, 1'b0, "len_zero");
      s0 = start_cnt;
      axi_write(5'h00, 32'h3, 4'hF, OK, 1'b0, "start_len0");
      check("len0_nostrobe", start_cnt - s0, 32'd0);
      axi_read(5'h04, 32'h4, OK, 1'b0, "status_err");
      check("irq_err", 32'(irq), 32'd1);
      axi_write(5'h04, 32'h4, 4'hF, OK, 1'b0, "w1c_err");
      axi_read(5'h04, 32'h0, OK, 1'b0, "status_clr");

      // eng_done against W1C of DONE: set wins
      axi_write(5'h10, 32'h40, 4'hF, OK, 1'b0, "len_restore");
      axi_write(5'h00, 32'h3, 4'hF, OK, 1'b0, "start2");
      axi_write(5'h04, 32'h2, 4'hF, OK, 1'b1, "w1c_vs_done");
      axi_read(5'h04, 32'h2, OK, 1'b0, "done_wins");

      // STATUS read coincident with eng_done sees pre-update value
      axi_write(5'h00, 32'h3, 4'hF, OK, 1'b0, "start3");
      axi_read(5'h04, 32'h1, OK, 1'b1, "status_pre");
      axi_read(5'h04, 32'h2, OK, 1'b0, "status_post");

      // START commit coincident with eng_done: START wins
      axi_write(5'h00, 32'h3, 4'hF, OK, 1'b0, "start4");
      s0 = start_cnt;
      axi_write(5'h00, 32'h3, 4'hF, OK, 1'b1, "start_vs_done");
      check("start_vs_done_strobe", start_cnt - s0, 32'd1);
      axi_read(5'h04, 32'h1, OK, 1'b0, "start_wins");

      // Engine error keeps BUSY
      pulse(1'b1);
      axi_read(5'h04, 32'h5, OK, 1'b0, "status_eng_err");
      check("irq_eng_err", 32'(irq), 32'd1);

      // Asynchronous reset during a start strobe
      pulse(1'b0);
      S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h3; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      @(posedge S_AXI_ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check("pre_reset_start", 32'(start), 32'd1);
      S_AXI_ARESET = 1'b1;
      #1;
      check("async_rst_out", {29'd0, start, S_AXI_BVALID, irq}, 32'h0);
      check("async_rst_ready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);
      check("async_rst_dst", address_dst, 32'h0);
      @(posedge S_AXI_ACLK); #1;
      S_AXI_ARESET = 1'b0;
      axi_read(5'h04, 32'h0, OK, 1'b0, "post_rst_status");
      axi_read(5'h14, 32'h0, OK, 1'b0, "post_rst_data");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
